// File: rtl/dsp_cfg_pkg.sv
// Shared types and elaboration-time helpers for the DSP config chain loader.
package dsp_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // Counters need at least one bit even when they only ever hold zero.
  function automatic int cnt_width(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/dsp_cfg_chain_loader_if.sv
// Word stream from the system config port into the chain loader.
interface dsp_cfg_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dsp_cfg_shifter.sv
// Holds the current bitstream word and serialises it LSB first, flagging the last valid bit.
module dsp_cfg_shifter
  import dsp_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              last_word,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              bit_last
);

  localparam int NWORDS    = nwords(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int BCNT_W    = cnt_width(WORD_W);
  localparam logic [BCNT_W-1:0] FULL_END = BCNT_W'(WORD_W - 1);
  localparam logic [BCNT_W-1:0] LAST_END = BCNT_W'(LAST_BITS - 1);

  logic [WORD_W-1:0] word_q;
  logic [BCNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      word_q  <= data;
      bit_cnt <= '0;
    end else if (shift) begin
      word_q  <= word_q >> 1;
      bit_cnt <= bit_cnt + BCNT_W'(1);
    end
  end

  assign bit_out = word_q[0];
  // The final word is short when CHAIN_LEN is not a multiple of WORD_W.
  assign bit_last = (bit_cnt == (last_word ? LAST_END : FULL_END));

endmodule

// File: rtl/dsp_cfg_chain_loader.sv
// Loads a bitstream word by word into a DSP column config chain and optionally reads it back by rotation.
module dsp_cfg_chain_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   verify_en,
  input  logic                   abort,
  dsp_cfg_chain_loader_if.slave  s,
  output logic                   cfg_in,
  output logic                   cfg_en,
  input  logic                   cfg_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
  localparam int WCNT_W = cnt_width(NWORDS);
  localparam int VCNT_W = cnt_width(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(CHAIN_LEN - 1);

  state_t                 state, state_nxt;
  logic                   verify_q;
  logic [WCNT_W-1:0]      word_cnt;
  logic [VCNT_W-1:0]      vcnt;
  logic [CHAIN_LEN-1:0]   shadow;
  logic                   accept, capture, last_word, shift_bit, bit_last;

  // Shadow mirrors the chain: bit 0 is the one nearest cfg_out once the load is complete.
  function automatic logic [CHAIN_LEN-1:0] push_bit(input logic [CHAIN_LEN-1:0] sh, input logic b);
    return (sh >> 1) | (CHAIN_LEN'(b) << (CHAIN_LEN - 1));
  endfunction

  assign accept    = (state == ST_IDLE) && start && !abort;
  assign capture   = (state == ST_LOAD) && s.valid;
  assign last_word = (word_cnt == WORD_LAST);

  dsp_cfg_shifter #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .shift     (state == ST_SHIFT),
    .last_word (last_word),
    .data      (s.data),
    .bit_out   (shift_bit),
    .bit_last  (bit_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   if (s.valid) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (bit_last) state_nxt = !last_word ? ST_LOAD : (verify_q ? ST_VERIFY : ST_DONE);
      ST_VERIFY: if (vcnt == VCNT_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_q <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
      vcnt     <= '0;
      shadow   <= '0;
    end else if (accept) begin
      verify_q <= verify_en;
      err      <= 1'b0;
      word_cnt <= '0;
      vcnt     <= '0;
    end else if (state == ST_SHIFT) begin
      shadow <= push_bit(shadow, shift_bit);
      if (bit_last && !last_word) word_cnt <= word_cnt + WCNT_W'(1);
    end else if (state == ST_VERIFY) begin
      // Rotate the shadow in step with the chain so bit 0 always lines up with cfg_out.
      shadow <= push_bit(shadow, shadow[0]);
      vcnt   <= vcnt + VCNT_W'(1);
      if (cfg_out != shadow[0]) err <= 1'b1;
    end
  end

  assign s.ready = (state == ST_LOAD);
  assign cfg_en  = (state == ST_SHIFT) || (state == ST_VERIFY);
  assign cfg_in  = (state == ST_SHIFT)  ? shift_bit :
                   (state == ST_VERIFY) ? cfg_out   : 1'b0;
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_dsp_cfg_chain_loader.sv
// Directed bench: models the 20-bit config chain and checks load, readback, stall, abort and reset behaviour.
module tb_dsp_cfg_chain_loader;

  logic clk, rst_n, start, verify_en, abort, cfg_in, cfg_en, cfg_out, busy, done, err;
  logic flip;
  logic [19:0] chain = '0;
  logic [7:0]  words [3];
  int checks = 0;
  int errors = 0;

  dsp_cfg_chain_loader_if #(.WORD_W(8)) bus ();

  dsp_cfg_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .verify_en (verify_en),
    .abort     (abort),
    .s         (bus),
    .cfg_in    (cfg_in),
    .cfg_en    (cfg_en),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: shifts toward bit 0 on every enabled clock; flip corrupts bit 5 on that edge.
  always_ff @(posedge clk)
    chain <= (cfg_en ? {cfg_in, chain[19:1]} : chain) ^ (flip ? 20'h00020 : 20'h00000);
  assign cfg_out = chain[0];

  typedef struct {
    logic        ver;
    int          stall;
    int          flip_cyc;
    int          abort_cyc;
    int          extra_start;
    logic [7:0]  w2;
    int          done_at;
    int          en_n;
    int          done_n;
    logic        err;
    logic        chk_chain;
    logic [19:0] chain;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_load(input logic ver, input int stall_n, input int flip_cyc, input int abort_cyc,
                          input int extra_start, input int rst_cyc,
                          output int done_at, output int en_n, output int done_n, output int stall_err,
                          output logic [3:0] post_abort, output logic [19:0] chain24,
                          output logic [5:0] rst_outs, output logic [1:0] pre_rst);
    int   widx, stall_left;
    logic hs;
    widx = 0; stall_left = stall_n;
    done_at = -1; en_n = 0; done_n = 0; stall_err = 0;
    post_abort = 4'hF; chain24 = '0; rst_outs = 6'h3F; pre_rst = 2'b00;
    verify_en = ver;
    for (int cyc = 0; cyc < 150; cyc++) begin
      start = (cyc == 0) || (cyc == extra_start);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = cyc;
      end
      if (cfg_en) en_n++;
      if (cyc == abort_cyc + 1) post_abort = {busy, cfg_en, bus.ready, done};
      if (cyc == 24) chain24 = chain;
      abort = (cyc == abort_cyc);
      flip  = (cyc == flip_cyc);
      bus.data  = words[(widx > 2) ? 2 : widx];
      bus.valid = 1'b1;
      if (bus.ready && widx == 1 && stall_left > 0) begin
        bus.valid = 1'b0;
        stall_left--;
        if (cfg_en) stall_err++;
      end
      hs = bus.ready && bus.valid;
      if (cyc == rst_cyc) begin
        pre_rst = {busy, cfg_en};
        #2 rst_n = 1'b0;
        #1 rst_outs = {cfg_en, cfg_in, busy, done, err, bus.ready};
        break;
      end
      if (done_at >= 0 && cyc >= done_at + 2) break;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 3) break;
      @(posedge clk); #1;
      if (hs) widx++;
    end
    start = 1'b0; abort = 1'b0; flip = 1'b0; bus.valid = 1'b0;
  endtask

  initial begin
    int          d_at, e_n, d_n, s_err;
    logic [3:0]  p_ab;
    logic [19:0] c24;
    logic [5:0]  r_o;
    logic [1:0]  p_r;

    //            ver  stall flip abort extra w2     done en  dn err  chk  chain
    vecs[0] = '{1'b0, 0, -1, -1, -1, 8'h0F, 24, 20, 1, 1'b0, 1'b1, 20'hF3CA5};
    vecs[1] = '{1'b1, 0, -1, -1,  5, 8'h0F, 44, 40, 1, 1'b0, 1'b1, 20'hF3CA5};
    vecs[2] = '{1'b1, 0, 23, -1, -1, 8'h0F, 44, 40, 1, 1'b1, 1'b1, 20'hF3C85};
    vecs[3] = '{1'b0, 3, -1, -1, -1, 8'h0F, 27, 20, 1, 1'b0, 1'b1, 20'hF3CA5};
    vecs[4] = '{1'b0, 0, -1,  8, -1, 8'h0F, -1,  7, 0, 1'b0, 1'b0, 20'h00000};
    vecs[5] = '{1'b0, 0, -1, -1, -1, 8'h0F, 24, 20, 1, 1'b0, 1'b1, 20'hF3CA5};

    rst_n = 1'b0; start = 1'b0; verify_en = 1'b0; abort = 1'b0; flip = 1'b0;
    bus.data = '0; bus.valid = 1'b0;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy",   32'(busy),      32'd0);
    chk("reset_done",   32'(done),      32'd0);
    chk("reset_err",    32'(err),       32'd0);
    chk("reset_cfg_en", 32'(cfg_en),    32'd0);
    chk("reset_cfg_in", 32'(cfg_in),    32'd0);
    chk("reset_ready",  32'(bus.ready), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      words[2] = vecs[i].w2;
      run_load(vecs[i].ver, vecs[i].stall, vecs[i].flip_cyc, vecs[i].abort_cyc, vecs[i].extra_start, -1,
               d_at, e_n, d_n, s_err, p_ab, c24, r_o, p_r);
      chk($sformatf("row%0d_done_at", i), 32'(d_at),  32'(vecs[i].done_at));
      chk($sformatf("row%0d_cfg_en_cycles", i), 32'(e_n), 32'(vecs[i].en_n));
      chk($sformatf("row%0d_done_pulses", i), 32'(d_n), 32'(vecs[i].done_n));
      chk($sformatf("row%0d_stall_cfg_en", i), 32'(s_err), 32'd0);
      chk($sformatf("row%0d_err", i), 32'(err), 32'(vecs[i].err));
      if (vecs[i].chk_chain) chk($sformatf("row%0d_chain", i), 32'(chain), 32'(vecs[i].chain));
      if (vecs[i].abort_cyc >= 0) chk($sformatf("row%0d_after_abort", i), 32'(p_ab), 32'd0);
      repeat (3) @(posedge clk);
      #1 chk($sformatf("row%0d_err_sticky", i), 32'(err), 32'(vecs[i].err));
    end

    // Reset during readback, with a stray start while busy and a word 3 whose upper nibble must be dropped.
    words[2] = 8'hF5;
    run_load(1'b1, 0, -1, -1, 26, 30, d_at, e_n, d_n, s_err, p_ab, c24, r_o, p_r);
    chk("rst_chain_loaded", 32'(c24), 32'h53CA5);
    chk("rst_pre_state",    32'(p_r), 32'h3);
    chk("rst_async_outs",   32'(r_o), 32'h0);
    chk("rst_no_done",      32'(d_n), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_idle_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
